// File: rtl/seq_det_pkg.sv
// ============================================================================
// Module : seq_det_pkg
// Purpose: Shared types and helpers for the scheduled sequence detector.
//          FSM state encoding, default pattern constants and width helpers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam int             DEF_PAT_W   = 4;
  localparam logic [3:0]     DEF_PATTERN = 4'b1001;

  // Channel-index width; a single requester still needs one bit of index.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width that can hold any count from 0 to d inclusive.
  function automatic int cnt_w(input int d);
    return $clog2(d + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_det_core.sv
// ============================================================================
// Module : seq_det_core
// Purpose: Serial windowed pattern matcher. Shifts one bit per enabled cycle
//          into a PAT_W-bit window and counts (overlapping) matches once at
//          least PAT_W bits of the current word have been seen.
// Ports  : clk, reset (async, active-low)
//          clear       - synchronous clear of window, bit count, match count
//          bit_in      - serial data bit
//          bit_en      - bit_in is valid this cycle
//          match_count - matches counted since the last clear
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_det_core import seq_det_pkg::*; #(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
  parameter int               CNT_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             bit_in,
  input  logic             bit_en,
  output logic [CNT_W-1:0] match_count
);

  // Bits-seen counter only needs to reach PAT_W-1; it then saturates.
  localparam int SEEN_W = $clog2(PAT_W);

  logic [PAT_W-1:0]  win_q,  win_d;
  logic [SEEN_W-1:0] seen_q, seen_d;
  logic [CNT_W-1:0]  cnt_q,  cnt_d;

  logic [PAT_W-1:0]  w_win_next;
  logic              w_full;
  logic              w_hit;

  always_comb begin
    w_win_next = {win_q[PAT_W-2:0], bit_in};
    // Window already holds PAT_W-1 bits of this word, so the bit arriving
    // now completes a full window.
    w_full     = (seen_q == SEEN_W'(PAT_W - 1));
    w_hit      = bit_en && w_full && (w_win_next == PATTERN);

    win_d  = win_q;
    seen_d = seen_q;
    cnt_d  = cnt_q;
    if (clear) begin
      win_d  = '0;
      seen_d = '0;
      cnt_d  = '0;
    end else if (bit_en) begin
      win_d = w_win_next;
      if (!w_full) seen_d = seen_q + SEEN_W'(1);
      if (w_hit)   cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_q  <= '0;
      seen_q <= '0;
      cnt_q  <= '0;
    end else begin
      win_q  <= win_d;
      seen_q <= seen_d;
      cnt_q  <= cnt_d;
    end
  end

  assign match_count = cnt_q;

endmodule

`default_nettype wire

// File: rtl/seq_det_sched.sv
// ============================================================================
// Module : seq_det_sched
// Purpose: Round-robin scheduler sharing one serial pattern detector among
//          NUM_CH requesters. A granted word is shifted MSB-first through
//          seq_det_core and the match count is returned tagged with channel.
// Ports  : clk, reset (async, active-low)
//          req_valid/req_data/req_ready - per-channel request handshake
//          res_valid/res_ch/res_count/res_ready - result handshake
//          busy - engine not idle
//          stat_sel/stat_total - per-channel accumulated count readback,
//          present only when SEQ_DET_SCHED_STATS_EN is defined
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_det_sched import seq_det_pkg::*; #(
  parameter int               NUM_CH  = 4,
  parameter int               DATA_W  = 8,
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
  localparam int              CH_W    = ch_w(NUM_CH),
  localparam int              CNT_W   = cnt_w(DATA_W)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH*DATA_W-1:0] req_data,
  output logic [NUM_CH-1:0]        req_ready,
  output logic                     res_valid,
  output logic [CH_W-1:0]          res_ch,
  output logic [CNT_W-1:0]         res_count,
  input  logic                     res_ready,
  output logic                     busy
`ifdef SEQ_DET_SCHED_STATS_EN
  ,
  input  logic [CH_W-1:0]          stat_sel,
  output logic [15:0]              stat_total
`endif
);

  localparam int BIT_W = $clog2(DATA_W);

  state_t            state_q, state_d;
  logic [CH_W-1:0]   last_q,  last_d;
  logic [CH_W-1:0]   gnt_q,   gnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0]  bit_q,   bit_d;

  logic              w_found;
  logic [CH_W-1:0]   w_gnt;
  logic [CH_W-1:0]   w_idx;
  logic [NUM_CH-1:0] w_onehot;
  logic              w_hs;
  logic [CNT_W-1:0]  w_count;

  // Round-robin search starting just after the last served channel.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      w_idx = CH_W'((int'(last_q) + k) % NUM_CH);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_gnt   = w_idx;
      end
    end
  end

  // Grant is only offered in IDLE, and never while reset is asserted.
  always_comb begin
    w_onehot = '0;
    if (w_found && (state_q == IDLE) && reset) w_onehot[w_gnt] = 1'b1;
  end

  assign req_ready = w_onehot;
  assign w_hs      = |(req_valid & w_onehot);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    case (state_q)
      IDLE: begin
        if (w_hs) begin
          gnt_d   = w_gnt;
          shreg_d = req_data[w_gnt*DATA_W +: DATA_W];
          bit_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
        bit_d   = bit_q + BIT_W'(1);
        if (bit_q == BIT_W'(DATA_W - 1)) state_d = REPORT;
      end
      REPORT: begin
        if (res_ready) begin
          last_d  = gnt_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= CH_W'(NUM_CH - 1);
      gnt_q   <= '0;
      shreg_q <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
    end
  end

  // Core is cleared on the accepting handshake so nothing carries across
  // words; its count is final on entry to REPORT and frozen there.
  seq_det_core #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN),
    .CNT_W   (CNT_W)
  ) u_core (
    .clk         (clk),
    .reset       (reset),
    .clear       (w_hs),
    .bit_in      (shreg_q[DATA_W-1]),
    .bit_en      (state_q == SHIFT),
    .match_count (w_count)
  );

  assign res_valid = (state_q == REPORT);
  assign busy      = (state_q != IDLE);
  assign res_ch    = gnt_q;
  assign res_count = w_count;

`ifdef SEQ_DET_SCHED_STATS_EN
  logic [NUM_CH*16-1:0] w_acc_flat;
  logic                 w_res_hs;

  assign w_res_hs = res_valid & res_ready;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_stats
    logic [15:0] acc_q;
    logic [16:0] w_sum;

    assign w_sum = {1'b0, acc_q} + 17'(res_count);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        acc_q <= '0;
      end else if (w_res_hs && (gnt_q == CH_W'(c))) begin
        acc_q <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
      end
    end

    assign w_acc_flat[c*16 +: 16] = acc_q;
  end

  assign stat_total = w_acc_flat[stat_sel*16 +: 16];
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_det_sched.sv
// ============================================================================
// Module : tb_seq_det_sched
// Purpose: Self-checking bench for seq_det_sched. A driver feeds per-channel
//          word queues; a monitor predicts grants, result timing and counts
//          from a behavioural model and compares against a scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_seq_det_sched;

  localparam int             NUM_CH = 4;
  localparam int             DATA_W = 8;
  localparam int             PAT_W  = 4;
  localparam int             CH_W   = 2;
  localparam int             CNT_W  = 4;
  localparam logic [PAT_W-1:0] PAT  = 4'b1001;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic [NUM_CH-1:0]        req_valid = '0;
  logic [NUM_CH*DATA_W-1:0] req_data = '0;
  logic [NUM_CH-1:0]        req_ready;
  logic                     res_valid;
  logic [CH_W-1:0]          res_ch;
  logic [CNT_W-1:0]         res_count;
  logic                     res_ready = 1'b1;
  logic                     busy;
`ifdef SEQ_DET_SCHED_STATS_EN
  logic [CH_W-1:0]          stat_sel = '0;
  logic [15:0]              stat_total;
  int                       m_acc [NUM_CH];
`endif

  always #5 clk = ~clk;

  seq_det_sched #(
    .NUM_CH  (NUM_CH),
    .DATA_W  (DATA_W),
    .PAT_W   (PAT_W),
    .PATTERN (PAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ch    (res_ch),
    .res_count (res_count),
    .res_ready (res_ready),
    .busy      (busy)
`ifdef SEQ_DET_SCHED_STATS_EN
    ,
    .stat_sel  (stat_sel),
    .stat_total(stat_total)
`endif
  );

  typedef struct {
    int ch;
    int cnt;
    int t;
  } exp_t;

  int                errors = 0;
  int                checks = 0;
  int                cyc = 0;
  exp_t              sb [$];
  logic [DATA_W-1:0] wq [NUM_CH][$];
  logic [NUM_CH-1:0] done_mask = '0;
  int                m_last = NUM_CH - 1;
  bit                eng_busy = 1'b0;
  bit                drop_en = 1'b0;
  bit                gap_en = 1'b0;

  // monitor scratch
  logic [NUM_CH-1:0] exp_rdy;
  bit                exp_rv;
  exp_t              e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Overlapping occurrences of PAT scanning the word MSB first.
  function automatic int exp_count(input logic [DATA_W-1:0] w);
    int n = 0;
    for (int i = DATA_W - 1; i >= PAT_W - 1; i--)
      if (w[i -: PAT_W] == PAT) n++;
    return n;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_req_ready", int'(req_ready), 0);
      chk("rst_res_valid", int'(res_valid), 0);
      chk("rst_res_ch",    int'(res_ch),    0);
      chk("rst_res_count", int'(res_count), 0);
      chk("rst_busy",      int'(busy),      0);
      sb.delete();
      m_last   = NUM_CH - 1;
      eng_busy = 1'b0;
`ifdef SEQ_DET_SCHED_STATS_EN
      for (int c = 0; c < NUM_CH; c++) m_acc[c] = 0;
`endif
    end else begin
      chk("busy", int'(busy), int'(eng_busy));
      exp_rdy = '0;
      if (!eng_busy) begin
        for (int k = 1; k <= NUM_CH; k++) begin
          if (req_valid[(m_last + k) % NUM_CH]) begin
            exp_rdy[(m_last + k) % NUM_CH] = 1'b1;
            break;
          end
        end
      end
      chk("req_ready", int'(req_ready), int'(exp_rdy));
      exp_rv = (sb.size() > 0) && (cyc >= sb[0].t + DATA_W + 1);
      chk("res_valid", int'(res_valid), int'(exp_rv));
      if (res_valid && exp_rv) begin
        chk("res_ch",    int'(res_ch),    sb[0].ch);
        chk("res_count", int'(res_count), sb[0].cnt);
        if (res_ready) begin
`ifdef SEQ_DET_SCHED_STATS_EN
          m_acc[sb[0].ch] = (m_acc[sb[0].ch] + sb[0].cnt > 65535) ? 65535
                            : m_acc[sb[0].ch] + sb[0].cnt;
`endif
          void'(sb.pop_front());
          eng_busy = 1'b0;
        end
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (req_valid[c] && req_ready[c]) begin
          e.ch  = c;
          e.cnt = exp_count(req_data[c*DATA_W +: DATA_W]);
          e.t   = cyc;
          sb.push_back(e);
          m_last       = c;
          eng_busy     = 1'b1;
          done_mask[c] = 1'b1;
        end
      end
    end
  end

  // ---------------- request driver ----------------
  always @(posedge clk) begin
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (done_mask[c]) begin
        done_mask[c] = 1'b0;
        void'(wq[c].pop_front());
        req_valid[c] = 1'b0;
      end
      if (drop_en && req_valid[c] && ($urandom_range(0, 7) == 0)) begin
        req_valid[c] = 1'b0;
      end else if (!req_valid[c] && (wq[c].size() > 0) &&
                   (!gap_en || ($urandom_range(0, 1) == 1))) begin
        req_valid[c] = 1'b1;
        req_data[c*DATA_W +: DATA_W] = wq[c][0];
      end
    end
  end

  function automatic bit pending();
    bit p = (sb.size() > 0) || eng_busy || (|req_valid);
    for (int c = 0; c < NUM_CH; c++) if (wq[c].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic drain(input int budget, input bit rnd_ready);
    int n = 0;
    while (pending() && n < budget) begin
      @(posedge clk); #1;
      if (rnd_ready) res_ready = ($urandom_range(0, 1) == 1);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: actual=%0d cycles required<%0d", n, budget);
    end
  endtask

  task automatic wait_sig(input string nm, input bit want_busy);
    int n = 0;
    while (((want_busy ? busy : res_valid) != 1'b1) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: actual=0 required=1", nm);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=timeout required=finish");
    $fatal(1, "global timeout");
  end

  logic [DATA_W-1:0] w;

  initial begin
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    res_ready = 1'b1;

    // ch0 overlap example
    wq[0].push_back(8'b1001_0010);
    drain(100, 1'b0);

    // ch2: zero word then two matches
    wq[2].push_back(8'h00);
    wq[2].push_back(8'b1001_1001);
    drain(100, 1'b0);

    // all channels valid: rotating grant order
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < NUM_CH; c++) begin
        w = DATA_W'($urandom);
        wq[c].push_back(w);
      end
    drain(300, 1'b0);

    // consumer stalls five cycles in REPORT
    res_ready = 1'b0;
    wq[3].push_back(8'b0100_1001);
    wait_sig("res_valid", 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    res_ready = 1'b1;
    drain(100, 1'b0);

    // no window carry between words
    wq[1].push_back(8'b0000_0100);
    wq[1].push_back(8'b1000_0000);
    drain(100, 1'b0);

    // randomized traffic with gaps, early drops and random backpressure
    gap_en  = 1'b1;
    drop_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       w = 8'b0100_1001;
        1:       w = 8'b1001_0010;
        default: w = DATA_W'($urandom);
      endcase
      wq[$urandom_range(0, NUM_CH - 1)].push_back(w);
    end
    drain(3000, 1'b1);
    gap_en  = 1'b0;
    drop_en = 1'b0;
    res_ready = 1'b1;

    // reset in SHIFT cycle 4 drops the in-flight word
    wq[2].push_back(8'b1001_1001);
    wait_sig("busy", 1'b1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c < NUM_CH; c++) wq[c].push_back(8'b1001_0010);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    drain(300, 1'b0);

`ifdef SEQ_DET_SCHED_STATS_EN
    wq[0].push_back(8'b1001_1001);
    wq[3].push_back(8'b0100_1001);
    drain(100, 1'b0);
    for (int s = 0; s < NUM_CH; s++) begin
      stat_sel = CH_W'(s);
      #1;
      chk("stat_total", int'(stat_total), m_acc[s]);
    end
`endif

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
